leibniz_pi_seq: RTL and testbench
=================================

# leibniz_pi_seq

Sequencer that computes a fixed-point approximation of pi with the Leibniz series, pi = 4·Σ(−1)^k/(2k+1). It sits directly upstream of the 32-bit non-restoring divider. For each term it issues one division (P_NUMERATOR / (2k+1)) over the divider's start/done handshake and consumes the quotient. It keeps a signed running sum and reports the final sum with a one-cycle done pulse.

## Interface
- P_WIDTH, 32, divider operand width.
- P_ACC_WIDTH, 40, signed accumulator width; must be ≥ P_WIDTH+2.
- P_NUMERATOR, 32'd4_000_000_000, dividend for every term (4·10^9 → pi scaled by 10^9).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- n_terms  in  P_WIDTH  number of series terms; sampled with start; must be < 2^(P_WIDTH−1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when pi_out is final.
- pi_out  out  P_ACC_WIDTH  signed sum; held from DONE until the next accepted start.
- term_idx  out  P_WIDTH  index k of the term in progress.
- div_start  out  1  divider start; high for exactly one cycle per term.
- div_dividend  out  P_WIDTH  constant P_NUMERATOR.
- div_divisor  out  P_WIDTH  2k+1, registered; stable from ISSUE through the cycle div_done is seen.
- div_quotient  in  P_WIDTH  divider quotient; valid when div_done=1.
- div_remainder  in  P_WIDTH  divider remainder; valid when div_done=1.
- div_done  in  1  divider completion pulse.

## Operation
- States: IDLE, ISSUE, WAIT, ACCUM, DONE. The state type is a 3-bit enum.
- IDLE, start=1, n_terms≠0:
  - Latch n_terms; clear the accumulator and k; load div_divisor=1.
  - Next state is ISSUE.
- IDLE, start=1, n_terms=0:
  - Clear the accumulator.
  - Next state is DONE, giving pi_out=0.
- ISSUE: div_start=1, decoded from state. Next state is WAIT.
- WAIT:
  - Hold until div_done=1, then capture div_quotient (and div_remainder) into a term register.
  - Next state is ACCUM.
  - div_done is ignored in every state except WAIT.
- ACCUM:
  - Add the zero-extended term to the accumulator if k is even; subtract it if k is odd.
  - If k = n_terms−1, go to DONE.
  - Otherwise k←k+1, div_divisor←div_divisor+2, and go to ISSUE.
- DONE:
  - done=1 for this single cycle.
  - pi_out←accumulator, registered on entry to DONE, so pi_out is valid in the same cycle done is high.
  - Next state is IDLE.
- start outside IDLE is ignored; there is no queueing.
- Arithmetic:
  - The term is unsigned, P_WIDTH bits, zero-extended to P_ACC_WIDTH.
  - The accumulator uses two's complement.
  - No saturation is needed: the partial sum is always in the range [0, P_NUMERATOR].
- The divider never receives divisor 0, so the zero-divide path is unused.

## Timing
- Reset values:
  - state=IDLE.
  - busy=0, done=0, div_start=0.
  - pi_out=0, term_idx=0.
  - div_divisor=1, div_dividend=P_NUMERATOR.
  - Accumulator and term register are 0.
- Start latency: start is accepted on edge N; div_start is high during cycle N+1.
- Per-term cycles: 1 (ISSUE) + L (WAIT, up to and including the div_done cycle) + 1 (ACCUM), where L is the divider latency.
- n_terms=0: done is high in the cycle after start is accepted.
- busy falls in the cycle after done. A new start is accepted in that IDLE cycle or any later one.
- Reset mid-run: return to IDLE immediately and clear all outputs. The parent resets the divider on the same reset. There is no partial result.
- div_done arriving in the same cycle as the entry into WAIT is legal and is captured.

## Configuration
- Macro: LEIBNIZ_PI_ROUND_EN.
- Defined: in ACCUM, term = quotient + 1 when 2·remainder ≥ divisor (compare at P_WIDTH+1 bits); this is round-half-up.
- Undefined: term = quotient (truncation); div_remainder is unused.

## Structure
- Package leibniz_pi_pkg contains:
  - state_t enum {IDLE, ISSUE, WAIT, ACCUM, DONE};
  - localparam LP_NUMERATOR_DEFAULT = 4_000_000_000.
- No internal sub-module. The divider is instantiated beside this block by the parent, with div_* wired point-to-point.

## Test plan
- Reset behaviour: assert rst asynchronously mid-cycle → all outputs take their reset values immediately; busy=0.
- n_terms=1 → exactly one div_start with divisor 1; done with pi_out=4000000000.
- n_terms=3 → div_start seen with divisors 1, 3, 5; pi_out=3466666667; term_idx reaches 2.
- n_terms=6 → divisors 1, 3, 5, 7, 9, 11; pi_out=2976046177 with the macro undefined, 2976046176 with LEIBNIZ_PI_ROUND_EN.
- n_terms=0 → no div_start; done one cycle after start; pi_out=0.
- Robustness, with a stub divider of random latency 1–40 cycles:
  - start pulsed while busy and a spurious div_done in ISSUE are both ignored;
  - rst asserted mid-run, then a new run with n_terms=2 gives pi_out=2666666667.

Source files
------------

// File: rtl/leibniz_pi_pkg.sv
// leibniz_pi_pkg: state encoding and default numerator shared by the Leibniz pi sequencer
package leibniz_pi_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, DONE} state_t;
    localparam logic [31:0] LP_NUMERATOR_DEFAULT = 32'd4_000_000_000;
endpackage

// File: rtl/leibniz_pi_seq.sv
// leibniz_pi_seq: sums 4e9*(-1)^k/(2k+1) over n_terms using an external divider handshake.
// Define LEIBNIZ_PI_ROUND_EN to round each quotient half-up instead of truncating.
module leibniz_pi_seq
    import leibniz_pi_pkg::*;
#(
    parameter int P_WIDTH = 32,
    parameter int P_ACC_WIDTH = 40,
    parameter logic [P_WIDTH-1:0] P_NUMERATOR = LP_NUMERATOR_DEFAULT
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [P_WIDTH-1:0]     n_terms,
    output logic                   busy,
    output logic                   done,
    output logic [P_ACC_WIDTH-1:0] pi_out,
    output logic [P_WIDTH-1:0]     term_idx,
    output logic                   div_start,
    output logic [P_WIDTH-1:0]     div_dividend,
    output logic [P_WIDTH-1:0]     div_divisor,
    input  logic [P_WIDTH-1:0]     div_quotient,
    input  logic [P_WIDTH-1:0]     div_remainder,
    input  logic                   div_done
);
    state_t state_q, state_d;
    logic [P_WIDTH-1:0] n_q, n_d, k_q, k_d, term_q, term_d, divisor_q, divisor_d;
    logic [P_ACC_WIDTH-1:0] acc_q, acc_d, pi_q, pi_d, term_ext;
`ifdef LEIBNIZ_PI_ROUND_EN
    logic [P_WIDTH-1:0] rem_q, rem_d;
    logic round_up;
    assign round_up = {rem_q, 1'b0} >= {1'b0, divisor_q};
    assign term_ext = P_ACC_WIDTH'(term_q) + P_ACC_WIDTH'(round_up);
`else
    logic unused_rem;
    assign unused_rem = ^div_remainder;
    assign term_ext = P_ACC_WIDTH'(term_q);
`endif
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign div_start = state_q == ISSUE;
    assign div_dividend = P_NUMERATOR;
    assign div_divisor = divisor_q;
    assign term_idx = k_q;
    assign pi_out = pi_q;
    always_comb begin
        state_d = state_q;
        n_d = n_q;
        k_d = k_q;
        term_d = term_q;
        divisor_d = divisor_q;
        acc_d = acc_q;
        pi_d = pi_q;
`ifdef LEIBNIZ_PI_ROUND_EN
        rem_d = rem_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                acc_d = '0;
                if (n_terms != '0) begin
                    n_d = n_terms;
                    k_d = '0;
                    divisor_d = P_WIDTH'(1);
                    state_d = ISSUE;
                end else begin
                    pi_d = '0;
                    state_d = DONE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (div_done) begin
                term_d = div_quotient;
`ifdef LEIBNIZ_PI_ROUND_EN
                rem_d = div_remainder;
`endif
                state_d = ACCUM;
            end
            ACCUM: begin
                // odd k terms are negative in the series
                acc_d = k_q[0] ? acc_q - term_ext : acc_q + term_ext;
                if (k_q == n_q - P_WIDTH'(1)) begin
                    pi_d = acc_d;
                    state_d = DONE;
                end else begin
                    k_d = k_q + P_WIDTH'(1);
                    divisor_d = divisor_q + P_WIDTH'(2);
                    state_d = ISSUE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q <= '0;
            k_q <= '0;
            term_q <= '0;
            divisor_q <= P_WIDTH'(1);
            acc_q <= '0;
            pi_q <= '0;
`ifdef LEIBNIZ_PI_ROUND_EN
            rem_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            k_q <= k_d;
            term_q <= term_d;
            divisor_q <= divisor_d;
            acc_q <= acc_d;
            pi_q <= pi_d;
`ifdef LEIBNIZ_PI_ROUND_EN
            rem_q <= rem_d;
`endif
        end
    end
endmodule

// File: tb/tb_leibniz_pi_seq.sv
// tb_leibniz_pi_seq: directed checks of leibniz_pi_seq against a behavioural divider stub
module tb_leibniz_pi_seq;
    localparam logic [31:0] NUM = 32'd4_000_000_000;
`ifdef LEIBNIZ_PI_ROUND_EN
    localparam logic [39:0] EXP6 = 40'd2976046176;
`else
    localparam logic [39:0] EXP6 = 40'd2976046177;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] n_terms = '0;
    logic busy, done, div_start;
    logic [39:0] pi_out;
    logic [31:0] term_idx, div_dividend, div_divisor;
    logic [31:0] div_quotient = '0, div_remainder = '0;
    logic div_done = 1'b0;
    int tests = 0, fails = 0;
    int lat_lo = 3, lat_hi = 3, cnt = 0;
    bit spur = 1'b0;
    logic [31:0] cur_div = 32'd1, max_k = '0;
    logic [31:0] divs[$];

    leibniz_pi_seq dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .busy(busy), .done(done), .pi_out(pi_out), .term_idx(term_idx),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
    );

    always #5 clk = ~clk;

    // divider stub: answers each div_start after a latency drawn from [lat_lo, lat_hi]
    always @(negedge clk) begin
        div_done = 1'b0;
        if (rst) cnt = 0;
        else if (div_start) begin
            divs.push_back(div_divisor);
            cur_div = div_divisor;
            cnt = int'($urandom_range(lat_hi, lat_lo));
            if (spur) begin
                div_done = 1'b1;
                div_quotient = 32'hDEAD_BEEF;
                div_remainder = 32'hFFFF_FFFF;
            end
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                div_done = 1'b1;
                div_quotient = NUM / cur_div;
                div_remainder = NUM % cur_div;
            end
        end
        if (busy && term_idx > max_k) max_k = term_idx;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_divs(input int n);
        check("div_count", 64'(divs.size()), 64'(n));
        for (int i = 0; i < n && i < divs.size(); i++)
            check("divisor", 64'(divs[i]), 64'(2 * i + 1));
    endtask

    task automatic run(input logic [31:0] n, input logic [39:0] exp_pi, input bit poke);
        divs.delete();
        max_k = '0;
        start = 1'b1;
        n_terms = n;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) check("zero_done_lat", 64'(done), 64'd1);
        else check("start_lat", 64'(div_start), 64'd1);
        for (int c = 0; c < 3000 && !done; c++) begin
            start = poke && c == 3;
            n_terms = poke ? 32'd7 : n;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 64'(done), 64'd1);
        check("pi_at_done", 64'(pi_out), 64'(exp_pi));
        @(negedge clk);
        check("busy_after", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd0);
        check("pi_held", 64'(pi_out), 64'(exp_pi));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_pi", 64'(pi_out), 64'd0);
        check("rst_term_idx", 64'(term_idx), 64'd0);
        check("rst_divisor", 64'(div_divisor), 64'd1);
        check("rst_dividend", 64'(div_dividend), 64'(NUM));
        rst = 1'b0;
        @(negedge clk);
        run(32'd1, 40'd4000000000, 1'b0);
        check_divs(1);
        run(32'd3, 40'd3466666667, 1'b0);
        check_divs(3);
        check("max_term_idx", 64'(max_k), 64'd2);
        run(32'd6, EXP6, 1'b0);
        check_divs(6);
        run(32'd0, 40'd0, 1'b0);
        check_divs(0);
        lat_lo = 1;
        lat_hi = 40;
        spur = 1'b1;
        run(32'd3, 40'd3466666667, 1'b1);
        check_divs(3);
        spur = 1'b0;
        start = 1'b1;
        n_terms = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("midrun_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_div_start", 64'(div_start), 64'd0);
        check("arst_pi", 64'(pi_out), 64'd0);
        check("arst_term_idx", 64'(term_idx), 64'd0);
        check("arst_divisor", 64'(div_divisor), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(32'd2, 40'd2666666667, 1'b0);
        check_divs(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
